// File: rtl/bram_shared.sv
// On-chip block-RAM responder for the multi-client arbiter protocol.
// Reads stream BURST words from a latched base; writes take one word per ack at a client-supplied address.
module bram_shared #(
  parameter int unsigned AN    = 24,
  parameter int unsigned DN    = 16,
  parameter int unsigned IN    = 4,
  parameter int unsigned BURST = 8,
  parameter int unsigned MN    = 12
) (
  input  logic              clkSYS,
  input  logic              reset,
  input  logic [IN*AN-1:0]  arb_addr,
  input  logic [IN*DN-1:0]  arb_data,
  input  logic [IN-1:0]     arb_wr,
  input  logic [IN-1:0]     arb_req,
  output logic [IN-1:0]     arb_ack,
  output logic [DN-1:0]     arb_data_out,
  output logic [IN-1:0]     arb_valid,
  output logic              busy
);

  localparam int unsigned GW = (IN > 1) ? $clog2(IN) : 1;
  localparam int unsigned CW = $clog2(BURST + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t        r_state, w_next;
  logic [GW-1:0] r_g, r_last, w_pick, w_idx;
  logic          w_any;
  logic [MN-1:0] r_base;
  logic [CW-1:0] r_cnt;
  logic [DN-1:0] r_mem [0:(1<<MN)-1];
  logic [DN-1:0] r_dout;
  logic [IN-1:0] r_valid;
  logic [MN-1:0] w_addr [IN];
  logic [DN-1:0] w_data [IN];
  logic          w_we;
  logic [MN-1:0] w_raddr;
  logic          w_unused_addr;

  // Only the low MN address bits select a word; upper bits alias.
  assign w_unused_addr = ^arb_addr;

  always_comb begin
    for (int unsigned i = 0; i < IN; i++) begin
      w_addr[i] = arb_addr[i*AN +: MN];
      w_data[i] = arb_data[i*DN +: DN];
    end
  end

  // Round-robin: first requester found searching upward from last+1.
  always_comb begin
    w_pick = r_last;
    w_idx  = '0;
    w_any  = 1'b0;
    for (int unsigned i = 1; i <= IN; i++) begin
      w_idx = GW'((32'(r_last) + i) % IN);
      if (!w_any && arb_req[w_idx]) begin
        w_pick = w_idx;
        w_any  = 1'b1;
      end
    end
  end

  assign w_we    = (r_state == WRITE) && arb_req[r_g] && arb_wr[r_g];
  assign w_raddr = r_base + MN'(r_cnt);

  always_comb begin
    w_next  = r_state;
    arb_ack = '0;
    case (r_state)
      IDLE: begin
        if (w_any) w_next = arb_wr[w_pick] ? WRITE : READ;
      end
      WRITE: begin
        arb_ack[r_g] = w_we;
        if (!w_we || r_cnt == CW'(BURST - 1)) w_next = IDLE;
      end
      READ: begin
        arb_ack[r_g] = (r_cnt == '0);
        if (r_cnt == CW'(BURST - 1)) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clkSYS) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= GW'(IN - 1);
      r_g     <= '0;
      r_base  <= '0;
      r_valid <= '0;
      r_dout  <= '0;
    end else begin
      r_state <= w_next;
      r_valid <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_g    <= w_pick;
            r_last <= w_pick;
            r_base <= w_addr[w_pick];
            r_cnt  <= '0;
          end
        end
        WRITE: begin
          if (w_we) r_cnt <= r_cnt + 1'b1;
        end
        READ: begin
          r_cnt        <= r_cnt + 1'b1;
          r_dout       <= r_mem[w_raddr];
          r_valid[r_g] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clkSYS) begin
    if (w_we) r_mem[w_addr[r_g]] <= w_data[r_g];
  end

  assign arb_data_out = r_dout;
  assign arb_valid    = r_valid;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_bram_shared.sv
// Directed bench for bram_shared: a reference memory image feeds an expected-read queue
// that is drained against arb_valid/arb_data_out every cycle.
module tb_bram_shared;
  localparam int AN = 24, DN = 16, IN = 4, BURST = 8, MN = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [IN*AN-1:0]  arb_addr;
  logic [IN*DN-1:0]  arb_data;
  logic [IN-1:0]     t_wr, t_req;
  logic [IN-1:0]     arb_ack, arb_valid;
  logic [DN-1:0]     arb_data_out;
  logic              busy;
  logic [AN-1:0]     t_addr [IN];
  logic [DN-1:0]     t_data [IN];

  for (genvar i = 0; i < IN; i++) begin : g_pack
    assign arb_addr[i*AN +: AN] = t_addr[i];
    assign arb_data[i*DN +: DN] = t_data[i];
  end

  bram_shared #(.AN(AN), .DN(DN), .IN(IN), .BURST(BURST), .MN(MN)) dut (
    .clkSYS(clk), .reset(rst), .arb_addr(arb_addr), .arb_data(arb_data),
    .arb_wr(t_wr), .arb_req(t_req), .arb_ack(arb_ack),
    .arb_data_out(arb_data_out), .arb_valid(arb_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [IN-1:0] v; logic [DN-1:0] d; } exp_t;
  exp_t          q[$];
  logic [DN-1:0] model [4096];
  int total, bad, nvalid, fv, lv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sample one cycle mid-period and retire any read word against the queue.
  task automatic smp;
    exp_t e;
    @(negedge clk); #1;
    if (arb_valid !== '0) begin
      chk("valid_onehot", 32'($onehot0(arb_valid)), 1);
      if (nvalid == 0) fv = cyc;
      lv = cyc;
      nvalid++;
      if (q.size() == 0) chk("unexpected_valid", 32'(arb_valid), 0);
      else begin
        e = q.pop_front();
        chk("valid_client", 32'(arb_valid), 32'(e.v));
        chk("rdata", 32'(arb_data_out), 32'(e.d));
      end
    end
  endtask

  task automatic drv;
    @(posedge clk); #1;
  endtask

  task automatic push_read(input int c, input int a);
    exp_t e;
    for (int k = 0; k < BURST; k++) begin
      e.v = IN'(1 << c);
      e.d = model[(a + k) & 'hFFF];
      q.push_back(e);
    end
  endtask

  task automatic drain;
    int g = 0;
    while ((q.size() != 0 || busy === 1'b1) && g < 60) begin
      smp; g++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic do_write(input int c, input int a, input int n, input int dbase,
                          input int dstep, output int acks, output int span);
    int guard = 0, f = -1, l = -1;
    acks = 0;
    drv;
    t_req[c] = 1'b1; t_wr[c] = 1'b1; t_addr[c] = AN'(a); t_data[c] = DN'(dbase);
    while (acks < n && guard < 40) begin
      smp; guard++;
      if (arb_ack !== '0) begin
        chk("wr_ack", 32'(arb_ack), 1 << c);
        model[(a + acks) & 'hFFF] = t_data[c];
        if (f < 0) f = cyc;
        l = cyc;
        acks++;
      end
      drv;
      if (acks < n) begin
        t_addr[c] = AN'(a + acks);
        t_data[c] = DN'(dbase + acks * dstep);
      end else begin
        t_req[c] = 1'b0; t_wr[c] = 1'b0;
      end
    end
    t_req[c] = 1'b0;
    span = l - f;
  endtask

  task automatic do_read(input int c, input int a, output int ack_cyc, output int req_cyc);
    int guard = 0;
    logic got = 1'b0;
    nvalid = 0; req_cyc = -1; ack_cyc = -100;
    drv;
    t_req[c] = 1'b1; t_wr[c] = 1'b0; t_addr[c] = AN'(a);
    while (!got && guard < 40) begin
      smp; guard++;
      if (req_cyc < 0) req_cyc = cyc;
      if (arb_ack !== '0) begin
        chk("rd_ack", 32'(arb_ack), 1 << c);
        ack_cyc = cyc;
        push_read(c, a);
        got = 1'b1;
      end
      drv;
      if (got) t_req[c] = 1'b0;
    end
    t_req[c] = 1'b0;
    chk("rd_ack_seen", 32'(got), 1);
    drain;
    chk("rd_nvalid", nvalid, BURST);
    chk("rd_first_valid", fv - ack_cyc, 1);
    chk("rd_last_valid", lv - ack_cyc, BURST);
  endtask

  initial begin
    int acks, span, ac, rc, g, order, prev;
    logic got;
    total = 0; bad = 0; nvalid = 0; fv = 0; lv = 0;
    rst = 1'b1; t_req = '0; t_wr = '0;
    for (int i = 0; i < IN; i++) begin t_addr[i] = '0; t_data[i] = '0; end
    repeat (3) @(posedge clk);
    smp;
    chk("rst_ack", 32'(arb_ack), 0);
    chk("rst_valid", 32'(arb_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dout", 32'(arb_data_out), 0);
    drv; rst = 1'b0;

    do_write(0, 'h100, 8, 'hA000, 1, acks, span); chk("pre100_acks", acks, 8);
    do_write(0, 'h300, 8, 'hB000, 1, acks, span); chk("pre300_acks", acks, 8);
    do_write(1, 'hFFE, 8, 'hC000, 1, acks, span); chk("preFFE_acks", acks, 8);

    do_read(1, 'h000100, ac, rc);
    chk("rd1_ack_latency", ac - rc, 1);

    do_write(2, 'h200, 8, 0, 'h1111, acks, span);
    chk("wr8_acks", acks, 8);
    chk("wr8_no_gaps", span, BURST - 1);
    smp;
    chk("wr8_idle_after", 32'(busy), 0);
    do_read(3, 'h000200, ac, rc);

    do_read(2, 'h000FFE, ac, rc);
    do_write(3, 'hFF1004, 8, 'hD000, 1, acks, span); chk("alias_wr_acks", acks, 8);
    do_read(0, 'h7FF004, ac, rc);
    do_read(1, 'h000000, ac, rc);

    do_write(2, 'h300, 3, 'hE000, 1, acks, span);
    chk("early_acks", acks, 3);
    smp;
    chk("early_no_ack", 32'(arb_ack), 0);
    chk("early_still_busy", 32'(busy), 1);
    smp;
    chk("early_idle", 32'(busy), 0);
    do_read(0, 'h000300, ac, rc);

    // All clients stream reads from reset.
    drv;
    rst = 1'b1; t_req = '1; t_wr = '0;
    t_addr[0] = 'h100; t_addr[1] = 'h300; t_addr[2] = 'h200; t_addr[3] = 'hFFE;
    drv; drv;
    rst = 1'b0;
    order = 0; prev = -1; g = 0;
    while (order < 6 && g < 100) begin
      smp; g++;
      if (arb_ack !== '0) begin
        chk("rr_grant", 32'(arb_ack), 1 << (order % IN));
        if (prev >= 0) chk("rr_gap", cyc - prev, BURST + 1);
        prev = cyc;
        push_read(order % IN, int'(t_addr[order % IN]));
        order++;
        if (order == 6) begin drv; t_req = '0; end
      end
    end
    t_req = '0;
    chk("rr_grants", order, 6);
    drain;

    // Reset in the middle of a read burst.
    nvalid = 0; got = 1'b0; g = 0;
    drv;
    t_req[2] = 1'b1; t_addr[2] = 'h200;
    while (!got && g < 20) begin
      smp; g++;
      if (arb_ack !== '0) begin
        push_read(2, 'h200);
        got = 1'b1;
      end
    end
    chk("mid_ack_seen", 32'(got), 1);
    drv; t_req[2] = 1'b0;
    g = 0;
    while (nvalid < 4 && g < 20) begin smp; g++; end
    chk("mid_four_valid", nvalid, 4);
    rst = 1'b1;
    t_req[0] = 1'b1; t_req[3] = 1'b1; t_addr[0] = 'h100; t_addr[3] = 'h300;
    q.delete();
    smp;
    chk("mid_rst_valid", 32'(arb_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    drv; rst = 1'b0;
    got = 1'b0; g = 0;
    while (!got && g < 20) begin
      smp; g++;
      if (arb_ack !== '0) begin
        chk("post_rst_grant", 32'(arb_ack), 1);
        push_read(0, 'h100);
        got = 1'b1;
      end
    end
    chk("post_rst_ack_seen", 32'(got), 1);
    drv; t_req = '0;
    drain;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bram_shared.md
# bram_shared

Multi-client on-chip block-RAM responder that implements the memory side of the system arbiter protocol used by `tft`, `rectfill`, `ppu_fb` and `mem_test`. Clients issue requests on per-client `req/addr/wr/data` lines. The block answers with `ack`, a shared read-data bus and per-client `valid` strobes, using the same burst semantics as the SDRAM path. It is a drop-in substitute for the external memory in simulation and a backing store for small on-chip buffers, such as palette and sprite scratch memory, on the NES side.

## Interface
Parameters:
- `AN`, 24: client address width.
- `DN`, 16: data word width.
- `IN`, 4: number of clients; client index 0 has highest priority after reset.
- `BURST`, 8: words per read burst and maximum words per write grant; ≥1.
- `MN`, 12: log2 of memory depth in words; only `addr[MN-1:0]` is used.

Ports:
- `clkSYS` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `arb_addr` in IN×AN: per-client word address.
- `arb_data` in IN×DN: per-client write data.
- `arb_wr` in IN×1: per-client 1 = write, 0 = read.
- `arb_req` in IN: per-client request, held until acked.
- `arb_ack` out IN: one-hot per-word (write) or per-burst (read) acceptance.
- `arb_data_out` out DN: shared read data.
- `arb_valid` out IN: one-hot, marks `arb_data_out` as belonging to that client.
- `busy` out 1: high whenever the FSM is not IDLE.

## Operation
- Memory: 2^MN × DN single-port synchronous RAM with 1-cycle read latency. Contents are not reset.
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - If any `arb_req` is set, pick the grant `g` round-robin, searching upward from `last+1` with wrap at IN. Latch `g` and `base = arb_addr[g][MN-1:0]`, clear `cnt`.
  - Go to WRITE if `arb_wr[g]` is set, else READ. `last <= g`.
  - No `ack` is asserted in IDLE.
- WRITE:
  - `arb_ack[g] = arb_req[g] & arb_wr[g]`, combinational.
  - On each acked cycle, write `arb_data[g]` at `arb_addr[g][MN-1:0]`. The client supplies the address per word and advances it after each ack.
  - `cnt` counts acked words.
  - Return to IDLE after the cycle where `cnt` reaches BURST, or in any cycle where `arb_req[g]` is low or `arb_wr[g]` is low (no ack in that cycle).
- READ:
  - `arb_ack[g]` is high in the first READ cycle only.
  - On READ cycles k = 0..BURST-1, issue a read at `(base + k) mod 2^MN`.
  - After the cycle with k = BURST-1, return to IDLE.
  - Read data is registered onto `arb_data_out`, with `arb_valid[g]` high in the following cycle, once per word, in address order.
- Address arithmetic: MN-bit wrap. Upper `addr` bits are ignored, never saturated.
- `arb_valid` and `arb_ack` are always one-hot or zero. `arb_data_out` is don't-care when no `valid` is set.
- Reset, including mid-burst:
  - FSM goes to IDLE, `cnt` = 0, `last` = IN-1.
  - All `arb_valid` are 0 from the next cycle, so the pending read pipeline is discarded.
  - Words already written stay written.

## Timing
- Reset values: `arb_ack` = 0, `arb_valid` = 0, `busy` = 0, `arb_data_out` = 0.
- Read, with the IDLE decision in cycle T:
  - `ack` at T+1.
  - `valid` and data at T+2 .. T+BURST+1.
  - IDLE again at T+BURST+1, which overlaps the last `valid` cycle.
  - Next grant's `ack` no earlier than T+BURST+2.
- Write, with the IDLE decision in cycle T:
  - First `ack` at T+1.
  - With `req` held continuously, BURST acks on T+1..T+BURST, then IDLE at T+BURST+1.
- Dead cycles:
  - One IDLE arbitration cycle between grants.
  - A back-to-back read stream from one client peaks at BURST words per BURST+1 cycles.
- A `req` deasserted before `ack` is legal: the grant proceeds only if still requesting in the WRITE case, while a READ started from IDLE always completes.
- A client raising `req` in the same cycle another's burst ends waits for the next IDLE.

## Test plan
- **Single read:** preload words 0x0100..0x0107 = 0xA000..0xA007. Client 1 issues a read at addr 0x000100 → one `ack[1]`; `valid[1]` for 8 consecutive cycles starting 2 cycles after the IDLE decision; data 0xA000..0xA007 in order.
- **Write then read back:** client 2 writes 8 words 0x1111·k at addr 0x0200+k → 8 acks with no gaps, FSM in IDLE after the 8th. Client 3 then reads 0x0200 → returns 0x0000, 0x1111 … 0x7777.
- **Round-robin:** all 4 clients request reads continuously from reset → grant order 0,1,2,3,0,… Each burst is separated by exactly one IDLE cycle, and `valid` never appears on two clients at once.
- **Wrap and early release:**
  - A read at 0x000FFE with MN = 12 returns words 0xFFE, 0xFFF, 0x000..0x005. Addr 0xFF1004 aliases to 0x004.
  - A write where the client drops `req` after 3 acks → exactly 3 words written, then IDLE.
- **Reset mid-burst:** assert `reset` on the 4th `valid` of a read → `valid` is 0 from the next cycle, `busy` = 0, and the next grant goes to client 0 first.
